// File: rtl/dual_dispatch_queue.sv
// Two-wide in-order dispatch queue between decode and issue: circular buffer, stall/flush aware.
// Optional build macro DDQ_PERF_EN adds a saturating issue-stall cycle counter (perf_stall_cnt).
module dual_dispatch_queue #(
  parameter int          DEPTH     = 8,
  parameter logic [3:0]  BRANCH_OP = 4'hC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_1_vld,
  input  logic [3:0]               in_1_op,
  input  logic [3:0]               in_1_des,
  input  logic [3:0]               in_1_s1,
  input  logic [3:0]               in_1_s2,
  input  logic [3:0]               in_1_ime,
  input  logic                     in_2_vld,
  input  logic [3:0]               in_2_op,
  input  logic [3:0]               in_2_des,
  input  logic [3:0]               in_2_s1,
  input  logic [3:0]               in_2_s2,
  input  logic [3:0]               in_2_ime,
  output logic                     in_rdy,
  input  logic                     entry_full,
  input  logic                     branch_full,
  input  logic                     flush_en,
  output logic                     ins_new_1_vld,
  output logic                     ins_new_2_vld,
  output logic [3:0]               ins_1_op,
  output logic [3:0]               ins_1_des,
  output logic [3:0]               ins_1_s1,
  output logic [3:0]               ins_1_s2,
  output logic [3:0]               ins_1_ime,
  output logic [3:0]               ins_2_op,
  output logic [3:0]               ins_2_des,
  output logic [3:0]               ins_2_s1,
  output logic [3:0]               ins_2_s2,
  output logic [3:0]               ins_2_ime,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_empty
`ifdef DDQ_PERF_EN
  ,
  output logic [15:0]              perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] des;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] ime;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  entry_t          in_1_ent;
  entry_t          in_2_ent;
  entry_t          slot_1;
  entry_t          slot_2;

  logic            stall;
  logic            push_en;
  logic            push_two;
  logic [CW-1:0]   push_cnt;
  logic [CW-1:0]   pop_cnt;

  assign in_1_ent = '{op: in_1_op, des: in_1_des, s1: in_1_s1, s2: in_1_s2, ime: in_1_ime};
  assign in_2_ent = '{op: in_2_op, des: in_2_des, s1: in_2_s1, s2: in_2_s2, ime: in_2_ime};

  // Slot fields always reflect head and head+1, whether or not they are valid.
  assign slot_1 = mem[head];
  assign slot_2 = mem[head + AW'(1)];

  assign ins_1_op  = slot_1.op;
  assign ins_1_des = slot_1.des;
  assign ins_1_s1  = slot_1.s1;
  assign ins_1_s2  = slot_1.s2;
  assign ins_1_ime = slot_1.ime;
  assign ins_2_op  = slot_2.op;
  assign ins_2_des = slot_2.des;
  assign ins_2_s1  = slot_2.s1;
  assign ins_2_s2  = slot_2.s2;
  assign ins_2_ime = slot_2.ime;

  // Readiness uses only the registered count; same-cycle pops are deliberately not credited.
  assign in_rdy  = !rst && ((CW'(DEPTH) - q_count) >= CW'(2));
  assign q_empty = (q_count == '0);

  assign stall = entry_full | branch_full | flush_en;

  always_comb begin
    ins_new_1_vld = 1'b0;
    ins_new_2_vld = 1'b0;
    if (!stall) begin
      ins_new_1_vld = (q_count >= CW'(1));
      // Only one branch ID can be handed out per cycle.
      ins_new_2_vld = (q_count >= CW'(2)) &&
                      !(slot_1.op == BRANCH_OP && slot_2.op == BRANCH_OP);
    end
  end

  assign push_en  = in_1_vld && in_rdy && !flush_en;
  assign push_two = push_en && in_2_vld;

  always_comb begin
    push_cnt = '0;
    if (push_two)     push_cnt = CW'(2);
    else if (push_en) push_cnt = CW'(1);
    pop_cnt = CW'(ins_new_1_vld) + CW'(ins_new_2_vld);
  end

  // NOTE: the entry array is reset too, so slot outputs read as zero after reset
  // rather than as uninitialised storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_en) begin
      mem[tail] <= in_1_ent;
      if (push_two) mem[tail + AW'(1)] <= in_2_ent;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else if (flush_en) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else begin
      head    <= head + AW'(pop_cnt);
      tail    <= tail + AW'(push_cnt);
      q_count <= q_count + push_cnt - pop_cnt;
    end
  end

`ifdef DDQ_PERF_EN
  // Counts cycles in which queued work is held back by the issue stage; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if ((q_count != '0) && (entry_full || branch_full) &&
                 (perf_stall_cnt != 16'hFFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_dispatch_queue.sv
// Self-checking bench for dual_dispatch_queue: vector table, scoreboard model and corner sequences.
module tb_dual_dispatch_queue;

  localparam int         DEPTH = 8;
  localparam logic [3:0] BR    = 4'hC;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] des;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] ime;
  } entry_t;

  typedef struct {
    logic       v1;
    logic       v2;
    logic [3:0] op1;
    logic [3:0] d1;
    logic [3:0] op2;
    logic [3:0] d2;
    logic       ef;
    logic       bf;
    logic       fl;
    int         exp_count;
    logic       exp_v1;
    logic       exp_v2;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_1_vld, in_2_vld;
  entry_t e1, e2;
  logic in_rdy, entry_full, branch_full, flush_en;
  logic ins_new_1_vld, ins_new_2_vld;
  logic [3:0] ins_1_op, ins_1_des, ins_1_s1, ins_1_s2, ins_1_ime;
  logic [3:0] ins_2_op, ins_2_des, ins_2_s1, ins_2_s2, ins_2_ime;
  logic [$clog2(DEPTH):0] q_count;
  logic q_empty;
`ifdef DDQ_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] exp_perf = '0;
`endif

  int checks = 0;
  int errors = 0;
  entry_t sb[$];
  vec_t   vecs[11];

  always #5 clk = ~clk;

  dual_dispatch_queue #(.DEPTH(DEPTH), .BRANCH_OP(BR)) dut (
    .clk(clk), .rst(rst),
    .in_1_vld(in_1_vld), .in_1_op(e1.op), .in_1_des(e1.des), .in_1_s1(e1.s1),
    .in_1_s2(e1.s2), .in_1_ime(e1.ime),
    .in_2_vld(in_2_vld), .in_2_op(e2.op), .in_2_des(e2.des), .in_2_s1(e2.s1),
    .in_2_s2(e2.s2), .in_2_ime(e2.ime),
    .in_rdy(in_rdy), .entry_full(entry_full), .branch_full(branch_full), .flush_en(flush_en),
    .ins_new_1_vld(ins_new_1_vld), .ins_new_2_vld(ins_new_2_vld),
    .ins_1_op(ins_1_op), .ins_1_des(ins_1_des), .ins_1_s1(ins_1_s1), .ins_1_s2(ins_1_s2),
    .ins_1_ime(ins_1_ime),
    .ins_2_op(ins_2_op), .ins_2_des(ins_2_des), .ins_2_s1(ins_2_s1), .ins_2_s2(ins_2_s2),
    .ins_2_ime(ins_2_ime),
    .q_count(q_count), .q_empty(q_empty)
`ifdef DDQ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic entry_t mk(input logic [3:0] op, input logic [3:0] des);
    return '{op: op, des: des, s1: des + 4'd1, s2: des + 4'd2, ime: ~des};
  endfunction

  task automatic drive(input logic v1, input logic v2, input logic [3:0] op1, input logic [3:0] d1,
                       input logic [3:0] op2, input logic [3:0] d2,
                       input logic ef, input logic bf, input logic fl);
    in_1_vld = v1;  in_2_vld = v2;
    e1 = mk(op1, d1);  e2 = mk(op2, d2);
    entry_full = ef;  branch_full = bf;  flush_en = fl;
  endtask

  // Called at the falling edge: compares against the model, advances it, moves past the next rising edge.
  task automatic model_step();
    logic stall, e_rdy, e_v1, e_v2;
    int n;
    stall = entry_full | branch_full | flush_en;
    n     = sb.size();
    e_rdy = (DEPTH - n) >= 2;
    e_v1  = !stall && n >= 1;
    e_v2  = 1'b0;
    if (!stall && n >= 2) e_v2 = !(sb[0].op == BR && sb[1].op == BR);
    check("in_rdy", 32'(in_rdy), 32'(e_rdy));
    check("q_count", 32'(q_count), 32'(n));
    check("q_empty", 32'(q_empty), 32'(n == 0));
    check("vld_1", 32'(ins_new_1_vld), 32'(e_v1));
    check("vld_2", 32'(ins_new_2_vld), 32'(e_v2));
    if (n >= 1) check("slot_1", 32'({ins_1_op, ins_1_des, ins_1_s1, ins_1_s2, ins_1_ime}), 32'(sb[0]));
    if (n >= 2) check("slot_2", 32'({ins_2_op, ins_2_des, ins_2_s1, ins_2_s2, ins_2_ime}), 32'(sb[1]));
`ifdef DDQ_PERF_EN
    check("perf_cnt", 32'(perf_stall_cnt), 32'(exp_perf));
    if (n >= 1 && (entry_full || branch_full) && exp_perf != 16'hFFFF) exp_perf++;
`endif
    if (flush_en) begin
      sb.delete();
    end else begin
      if (e_v1) void'(sb.pop_front());
      if (e_v2) void'(sb.pop_front());
      if (in_1_vld && e_rdy) begin
        sb.push_back(e1);
        if (in_2_vld) sb.push_back(e2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
  endtask

  task automatic idle(input logic ef, input logic bf);
    drive(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, ef, bf, 0);
  endtask

  // Called one time unit after a rising edge: pulses reset between edges and checks it takes effect with no edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_in_rdy"}, 32'(in_rdy), 32'd0);
    check({tag, "_count"}, 32'(q_count), 32'd0);
    check({tag, "_empty"}, 32'(q_empty), 32'd1);
    check({tag, "_vld_1"}, 32'(ins_new_1_vld), 32'd0);
    check({tag, "_vld_2"}, 32'(ins_new_2_vld), 32'd0);
    check({tag, "_slots"}, 32'({ins_1_op, ins_1_des, ins_1_s1, ins_1_s2, ins_1_ime,
                                ins_2_op, ins_2_des, ins_2_s1}), 32'd0);
`ifdef DDQ_PERF_EN
    check({tag, "_perf"}, 32'(perf_stall_cnt), 32'd0);
    exp_perf = '0;
`endif
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    rst = 1'b1;
    idle(0, 0);
    #3;
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_empty", 32'(q_empty), 32'd1);
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_vld", 32'({ins_new_1_vld, ins_new_2_vld}), 32'd0);
    check("rst_slot", 32'({ins_1_op, ins_1_des}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //            v1 v2 op1   d1    op2   d2    ef bf fl  cnt v1 v2
    vecs[0]  = '{1, 1, 4'h1, 4'h3, 4'h1, 4'h4, 0, 0, 0,  0, 0, 0};
    vecs[1]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0,  2, 1, 1};
    vecs[2]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 0};
    vecs[3]  = '{1, 1, BR,   4'h5, BR,   4'h6, 0, 0, 0,  0, 0, 0};
    vecs[4]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0,  2, 1, 0};
    vecs[5]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0,  1, 1, 0};
    vecs[6]  = '{1, 1, 4'h2, 4'h7, 4'h3, 4'h8, 1, 0, 0,  0, 0, 0};
    vecs[7]  = '{1, 0, 4'h2, 4'h9, 4'h0, 4'h0, 0, 1, 0,  2, 0, 0};
    vecs[8]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0,  3, 1, 1};
    vecs[9]  = '{0, 1, 4'h4, 4'hA, 4'h4, 4'hB, 0, 0, 0,  1, 1, 0};
    vecs[10] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v1, vecs[i].v2, vecs[i].op1, vecs[i].d1, vecs[i].op2, vecs[i].d2,
            vecs[i].ef, vecs[i].bf, vecs[i].fl);
      @(negedge clk);
      check($sformatf("vec%0d_count", i), 32'(q_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_vld_1", i), 32'(ins_new_1_vld), 32'(vecs[i].exp_v1));
      check($sformatf("vec%0d_vld_2", i), 32'(ins_new_2_vld), 32'(vecs[i].exp_v2));
      if (i == 1) check("vec1_des", 32'({ins_1_des, ins_2_des}), 32'h34);
      if (i == 5) check("vec5_branch2", 32'({ins_1_op, ins_1_des}), 32'hC6);
      model_step();
    end

    // Fill under entry_full until in_rdy drops; tail starts at DEPTH-1 so the first pair wraps.
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      drive(1, 1, 4'h5, 4'(2 * i), 4'h6, 4'(2 * i + 1), 1, 0, 0);
      @(negedge clk);
      if (!in_rdy) done = 1;
      model_step();
    end
    check("fill_bound", 32'(done), 32'd1);
    check("fill_count", 32'(q_count), 32'(DEPTH));
    check("fill_vld", 32'({ins_new_1_vld, ins_new_2_vld}), 32'd0);
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      idle(0, 0);
      cycle();
    end
    check("drain_empty", 32'(q_empty), 32'd1);

    // Count of DEPTH-1: in_rdy stays low even though two entries pop this cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'h7, 4'(i), 4'h8, 4'(i + 8), 1, 0, 0);
      cycle();
    end
    drive(1, 0, 4'h9, 4'hF, 4'h0, 4'h0, 1, 0, 0);
    cycle();
    drive(1, 1, 4'hA, 4'h1, 4'hA, 4'h2, 0, 0, 0);
    @(negedge clk);
    check("cnt7_count", 32'(q_count), 32'(DEPTH - 1));
    check("cnt7_in_rdy", 32'(in_rdy), 32'd0);
    check("cnt7_vld_2", 32'(ins_new_2_vld), 32'd1);
    model_step();
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      idle(0, 0);
      cycle();
    end
    check("cnt7_drained", 32'(q_empty), 32'd1);

    // Flush with five entries queued and a simultaneous push.
    drive(1, 1, 4'h1, 4'h1, 4'h1, 4'h2, 1, 0, 0);  cycle();
    drive(1, 1, 4'h1, 4'h3, 4'h1, 4'h4, 1, 0, 0);  cycle();
    drive(1, 0, 4'h1, 4'h5, 4'h0, 4'h0, 1, 0, 0);  cycle();
    drive(1, 1, 4'h2, 4'h6, 4'h2, 4'h7, 0, 0, 1);
    @(negedge clk);
    check("flush_pre_count", 32'(q_count), 32'd5);
    check("flush_vld", 32'({ins_new_1_vld, ins_new_2_vld}), 32'd0);
    model_step();
    idle(0, 0);
    @(negedge clk);
    check("post_flush_count", 32'(q_count), 32'd0);
    check("post_flush_vld", 32'(ins_new_1_vld), 32'd0);
    model_step();

    // Reset, load three entries, then hold branch_full for ten cycles and reset mid-stall.
    async_reset("rst1");
    drive(1, 1, 4'h3, 4'h1, 4'h3, 4'h2, 0, 0, 0);  cycle();
    drive(1, 0, 4'h3, 4'h3, 4'h0, 4'h0, 0, 1, 0);  cycle();
    for (int i = 0; i < 10; i++) begin
      idle(0, 1);
      cycle();
    end
    check("stall_count", 32'(q_count), 32'd3);
`ifdef DDQ_PERF_EN
    // One stalled cycle while loading the third entry, plus the ten held cycles.
    check("perf_total", 32'(perf_stall_cnt), 32'd11);
`endif
    async_reset("rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_dispatch_queue.md
# dual_dispatch_queue

In-order, two-wide instruction buffer directly upstream of the issue stage. It accepts up to two decoded instructions per cycle from decode and stores them in a circular queue. Each cycle it presents up to two instructions to the issue stage on the `ins_new_*` / `ins_1_*` / `ins_2_*` lines, and stalls on the issue stage's `entry_full` / `branch_full`. It empties on a branch flush.

## Interface
Parameters:
- `DEPTH`, 8: number of queue entries; a power of two, at least 4.
- `BRANCH_OP`, 4'hC: opcode value that is treated as a branch.

Ports (clock and reset first):
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_1_vld`  input  1  decode slot 1 valid; slot 1 is always the older instruction.
- `in_1_op` / `in_1_des` / `in_1_s1` / `in_1_s2` / `in_1_ime`  input  4 each  decode slot 1 fields.
- `in_2_vld`  input  1  decode slot 2 valid; ignored unless `in_1_vld` is also high.
- `in_2_op` / `in_2_des` / `in_2_s1` / `in_2_s2` / `in_2_ime`  input  4 each  decode slot 2 fields.
- `in_rdy`  output  1  queue can accept two instructions this cycle.
- `entry_full`  input  1  issue stage reservation entries are full.
- `branch_full`  input  1  issue stage has no free branch IDs.
- `flush_en`  input  1  branch mispredict flush.
- `ins_new_1_vld` / `ins_new_2_vld`  output  1 each  dispatch slot valid.
- `ins_1_op` / `ins_1_des` / `ins_1_s1` / `ins_1_s2` / `ins_1_ime`  output  4 each  oldest queued instruction.
- `ins_2_op` / `ins_2_des` / `ins_2_s1` / `ins_2_s2` / `ins_2_ime`  output  4 each  second-oldest queued instruction.
- `q_count`  output  $clog2(DEPTH)+1  number of occupied entries.
- `q_empty`  output  1  high when `q_count` == 0.

## Operation
- **Storage**
  - Circular array of 20-bit entries, each {op, des, s1, s2, ime}.
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `q_count` is a registered count.
- **Push**
  - Condition: `in_1_vld` && `in_rdy` && !`flush_en`.
  - Writes slot 1 at tail, and slot 2 at tail+1 if `in_2_vld`.
  - Tail advances by 1 or 2.
  - Inputs presented while `in_rdy` is low are dropped. Decode is required to hold them.
- **`in_rdy`**
  - Equals (DEPTH − `q_count`) ≥ 2, using the registered count.
  - Same-cycle pops are not credited.
  - Forced low while `rst` is high.
- **Dispatch**
  - `stall` = `entry_full` | `branch_full` | `flush_en`.
  - `ins_new_1_vld` = !`stall` && `q_count` ≥ 1.
  - `ins_new_2_vld` = !`stall` && `q_count` ≥ 2 && !(`ins_1_op` == BRANCH_OP && `ins_2_op` == BRANCH_OP). At most one branch ID is consumed per cycle.
  - Slot fields always show head and head+1, even when the valid is low.
  - Pop count equals the number of asserted valids. Head advances by that amount at the clock edge.
  - The issue stage accepts every asserted valid; there is no separate ack.
- **Count update**: `q_count` next = `q_count` + pushes − pops. A push and pop in the same cycle is legal.
- **Flush**: while `flush_en` is high, head, tail and count reset to 0 at the edge, all pushes that cycle are discarded, and both dispatch valids are low.
- **Priority**: `rst` > `flush_en` > push/pop.

## Timing
- Reset values:
  - Head, tail and `q_count` = 0; `q_empty` = 1.
  - `in_rdy` = 0 while `rst` is high, then 1.
  - `ins_new_1_vld` / `ins_new_2_vld` = 0.
  - Entry contents are don't-care; slot outputs are 0 after reset because the array is cleared.
- Push-to-dispatch latency is 1 cycle minimum: written at edge N, visible on the outputs in cycle N+1. There is no bypass.
- Dispatch outputs are combinational from registered state plus `entry_full` / `branch_full` / `flush_en`. There is no path from the decode inputs to the outputs.
- Full: with `q_count` = DEPTH−1 or DEPTH, `in_rdy` = 0, even if two pops occur that cycle.
- Wrap: when tail = DEPTH−1, the two-wide push writes entries DEPTH−1 and 0.
- Reset asserted mid-operation immediately clears all state and valids. This is asynchronous and takes no edge.

## Configuration
- Macro `DDQ_PERF_EN`.
  - Defined:
    - Adds output `perf_stall_cnt` (16 bits).
    - It increments, saturating at 16'hFFFF, on every cycle with `q_count` ≥ 1 and (`entry_full` | `branch_full`).
    - It clears on `rst` only; flush does not clear it.
  - Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then push two ALU ops (op 1, des 3/4) in cycle 0 → cycle 1: both valids = 1, `ins_1_des` = 3, `ins_2_des` = 4; cycle 2: `q_count` = 0, `q_empty` = 1.
- Hold `entry_full` = 1 and push pairs until `in_rdy` = 0 (DEPTH 8) → `q_count` = 7 or 8 and no valids. Release `entry_full` → the queue drains two per cycle in original order, including the entries across the tail wrap.
- Queue head holds op C, op C → only `ins_new_1_vld` asserts. The next cycle shows the second branch in slot 1.
- Queue has 5 entries and `flush_en` is pulsed with a simultaneous push → valids are 0 in the flush cycle, and the next cycle has `q_count` = 0 and no dispatch.
- `branch_full` = 1 for 10 cycles with `q_count` = 3 (with `DDQ_PERF_EN`) → `perf_stall_cnt` = 10. Assert `rst` mid-stall → all outputs go to their reset values without a clock edge.
